// File: rtl/bsg_cache_pkt_in_buffer.sv
// ============================================================================
// bsg_cache_pkt_in_buffer : two-entry registered staging FIFO for cache packets
// Revision: 1.0
// ============================================================================
`default_nettype none

module bsg_cache_pkt_in_buffer #(
  parameter int addr_width_p  = 28,
  parameter int data_width_p  = 32,
  localparam int mask_width_lp = data_width_p / 8,
  localparam int pkt_width_lp  = 5 + addr_width_p + data_width_p + mask_width_lp
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic                     v_i,
  input  logic [pkt_width_lp-1:0]  cache_pkt_i,
  output logic                     ready_o,
  output logic                     v_o,
  output logic [pkt_width_lp-1:0]  cache_pkt_o,
  output logic [4:0]               opcode_o,
  output logic [addr_width_p-1:0]  addr_o,
  output logic [data_width_p-1:0]  data_o,
  output logic [mask_width_lp-1:0] mask_o,
  input  logic                     yumi_i,
  output logic [1:0]               count_o
);

  localparam logic [1:0] C_FULL  = 2'd2;
  localparam logic [1:0] C_EMPTY = 2'd0;

  logic [pkt_width_lp-1:0] r_mem [2];
  logic                    r_wptr;
  logic                    r_rptr;
  logic [1:0]              r_count;

  logic w_enq;
  logic w_deq;

  // Handshake qualifiers depend only on registered occupancy, so there is no
  // combinational path from v_i or yumi_i to ready_o / v_o.
  assign ready_o = (r_count != C_FULL);
  assign v_o     = (r_count != C_EMPTY);
  assign w_enq   = v_i & ready_o;
  assign w_deq   = yumi_i & v_o;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wptr   <= 1'b0;
      r_rptr   <= 1'b0;
      r_count  <= C_EMPTY;
    end else begin
      if (w_enq) begin
        r_mem[r_wptr] <= cache_pkt_i;
        r_wptr        <= ~r_wptr;
      end
      if (w_deq) begin
        r_rptr <= ~r_rptr;
      end
      if (w_enq && !w_deq) begin
        r_count <= r_count + 2'd1;
      end else if (w_deq && !w_enq) begin
        r_count <= r_count - 2'd1;
      end
    end
  end

  assign cache_pkt_o = r_mem[r_rptr];
  assign count_o     = r_count;

  assign opcode_o = cache_pkt_o[pkt_width_lp-1 -: 5];
  assign addr_o   = cache_pkt_o[pkt_width_lp-6 -: addr_width_p];
  assign data_o   = cache_pkt_o[data_width_p+mask_width_lp-1 -: data_width_p];
  assign mask_o   = cache_pkt_o[mask_width_lp-1:0];

endmodule

`default_nettype wire

// File: tb/tb_bsg_cache_pkt_in_buffer.sv
// ============================================================================
// tb_bsg_cache_pkt_in_buffer : scoreboard bench for the cache packet in-buffer
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_bsg_cache_pkt_in_buffer;

  localparam int AW = 28;
  localparam int DW = 32;
  localparam int MW = DW / 8;
  localparam int PW = 5 + AW + DW + MW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          v_i = 1'b0;
  logic [PW-1:0] pkt_i = '0;
  logic          yumi_i = 1'b0;
  logic          ready_o, v_o;
  logic [PW-1:0] pkt_o;
  logic [4:0]    opcode_o;
  logic [AW-1:0] addr_o;
  logic [DW-1:0] data_o;
  logic [MW-1:0] mask_o;
  logic [1:0]    count_o;

  int n_vec = 0;
  int n_miss = 0;

  logic [PW-1:0] sb [$];
  logic [1:0]    m_count = 2'd0;
  logic          m_enq, m_deq;

  bsg_cache_pkt_in_buffer #(.addr_width_p(AW), .data_width_p(DW)) dut (
    .clk_i      (clk),
    .reset_n_i  (rst_n),
    .v_i        (v_i),
    .cache_pkt_i(pkt_i),
    .ready_o    (ready_o),
    .v_o        (v_o),
    .cache_pkt_o(pkt_o),
    .opcode_o   (opcode_o),
    .addr_o     (addr_o),
    .data_o     (data_o),
    .mask_o     (mask_o),
    .yumi_i     (yumi_i),
    .count_o    (count_o)
  );

  always #5 clk = ~clk;

  function automatic logic [PW-1:0] mkpkt(input logic [4:0] op, input logic [AW-1:0] a,
                                          input logic [DW-1:0] d, input logic [MW-1:0] m);
    return {op, a, d, m};
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference occupancy model and expected-packet queue.
  assign m_enq = v_i && (m_count != 2'd2);
  assign m_deq = yumi_i && (m_count != 2'd0);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_count <= 2'd0;
      sb.delete();
    end else begin
      if (yumi_i && m_count == 2'd0)
        $display("protocol note: yumi_i asserted while empty at %0t", $time);
      if (m_enq) sb.push_back(pkt_i);
      if (m_deq) void'(sb.pop_front());
      if (m_enq && !m_deq)      m_count <= m_count + 2'd1;
      else if (m_deq && !m_enq) m_count <= m_count - 2'd1;
    end
  end

  // Monitor: compares status every cycle and the head whenever it is valid.
  always @(negedge clk) begin
    chk("count_o", 128'(count_o), 128'(m_count));
    chk("v_o", 128'(v_o), 128'(m_count != 2'd0));
    chk("ready_o", 128'(ready_o), 128'(m_count != 2'd2));
    if (v_o) begin
      if (sb.size() == 0) begin
        chk("head_without_expect", 128'(pkt_o), 128'(0));
        chk("head_without_expect_v", 128'(1), 128'(0));
      end else begin
        chk("cache_pkt_o", 128'(pkt_o), 128'(sb[0]));
        chk("opcode_o", 128'(opcode_o), 128'(sb[0][PW-1 -: 5]));
        chk("addr_o", 128'(addr_o), 128'(sb[0][PW-6 -: AW]));
        chk("data_o", 128'(data_o), 128'(sb[0][DW+MW-1 -: DW]));
        chk("mask_o", 128'(mask_o), 128'(sb[0][MW-1:0]));
      end
    end
  end

  // Present a packet until accepted (bounded); called just after a rising edge.
  task automatic send(input logic [PW-1:0] p);
    logic acc;
    acc = 1'b0;
    v_i = 1'b1;
    pkt_i = p;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      acc = ready_o;
      @(posedge clk);
      #1;
      if (acc) break;
    end
    if (!acc) chk("send_timeout", 128'(0), 128'(1));
    v_i = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain(input int budget);
    yumi_i = 1'b0;
    for (int k = 0; k < budget; k++) begin
      if (!v_o) break;
      yumi_i = 1'b1;
      @(posedge clk);
      #1;
      yumi_i = 1'b0;
    end
    chk("drain_empty", 128'(v_o), 128'(0));
  endtask

  initial begin
    int idx;
    logic acc;

    // 1. Reset with junk on the input.
    v_i = 1'b1;
    pkt_i = {$urandom, $urandom, $urandom};
    #23;
    chk("rst_ready", 128'(ready_o), 128'(1));
    chk("rst_v", 128'(v_o), 128'(0));
    chk("rst_count", 128'(count_o), 128'(0));
    chk("rst_pkt", 128'(pkt_o), 128'(0));
    v_i = 1'b0;
    rst_n = 1'b1;
    idle(2);
    chk("post_rst_v", 128'(v_o), 128'(0));

    // 2. Single packet, explicit field values.
    send(mkpkt(5'h10, 28'h0ABCDE0, 32'hDEADBEEF, 4'hF));
    #1;
    chk("t2_v", 128'(v_o), 128'(1));
    chk("t2_op", 128'(opcode_o), 128'(5'h10));
    chk("t2_addr", 128'(addr_o), 128'(28'h0ABCDE0));
    chk("t2_data", 128'(data_o), 128'(32'hDEADBEEF));
    chk("t2_mask", 128'(mask_o), 128'(4'hF));
    chk("t2_count", 128'(count_o), 128'(1));
    yumi_i = 1'b1;
    @(posedge clk); #1;
    yumi_i = 1'b0;
    chk("t2_v_after_yumi", 128'(v_o), 128'(0));

    // 3. Fill, back-pressure, then drain A, B, C.
    send(mkpkt(5'h01, 28'h0000100, 32'd1, 4'h1));
    send(mkpkt(5'h02, 28'h0000200, 32'd2, 4'h3));
    chk("t3_full_count", 128'(count_o), 128'(2));
    chk("t3_full_ready", 128'(ready_o), 128'(0));
    v_i = 1'b1;
    pkt_i = mkpkt(5'h03, 28'h0000300, 32'd3, 4'h7);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk("t3_hold_ready", 128'(ready_o), 128'(0));
      chk("t3_head_A", 128'(data_o), 128'(32'd1));
    end
    yumi_i = 1'b1;
    @(posedge clk); #1;
    yumi_i = 1'b0;
    chk("t3_ready_after_yumi", 128'(ready_o), 128'(1));
    chk("t3_head_B", 128'(data_o), 128'(32'd2));
    @(posedge clk); #1;
    v_i = 1'b0;
    chk("t3_C_taken", 128'(count_o), 128'(2));
    yumi_i = 1'b1;
    @(posedge clk); #1;
    yumi_i = 1'b0;
    chk("t3_head_C", 128'(data_o), 128'(32'd3));
    drain(4);

    // 4. Streaming 100 packets with yumi following v_o.
    idx = 0;
    for (int cyc = 0; cyc < 400 && idx < 100; cyc++) begin
      v_i = 1'b1;
      pkt_i = mkpkt(5'(idx), 28'(idx), 32'(idx), 4'(idx));
      yumi_i = v_o;
      @(negedge clk);
      acc = ready_o;
      if (count_o > 2'd1) chk("t4_count_le1", 128'(count_o), 128'(1));
      @(posedge clk); #1;
      if (acc) idx++;
    end
    v_i = 1'b0;
    yumi_i = 1'b0;
    chk("t4_all_sent", 128'(idx), 128'(100));
    drain(4);

    // 5. Asynchronous reset while full.
    send(mkpkt(5'h1F, 28'hFFFFFFF, 32'hAAAA5555, 4'hA));
    send(mkpkt(5'h0E, 28'h1234567, 32'h5555AAAA, 4'h5));
    chk("t5_full", 128'(count_o), 128'(2));
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_rst_v", 128'(v_o), 128'(0));
    chk("t5_rst_count", 128'(count_o), 128'(0));
    chk("t5_rst_pkt", 128'(pkt_o), 128'(0));
    chk("t5_rst_data", 128'(data_o), 128'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(1);
    send(mkpkt(5'h04, 28'h0000040, 32'h12345678, 4'hC));
    chk("t5_first_after_rst", 128'(data_o), 128'(32'h12345678));
    drain(4);

    // 6. Stray yumi while empty, then a packet must survive intact.
    yumi_i = 1'b1;
    idle(5);
    yumi_i = 1'b0;
    chk("t6_still_empty", 128'(count_o), 128'(0));
    send(mkpkt(5'h0D, 28'h0D0D0D0, 32'hD00DD00D, 4'h9));
    idle(2);
    chk("t6_count", 128'(count_o), 128'(1));
    chk("t6_data", 128'(data_o), 128'(32'hD00DD00D));
    drain(4);
    send(mkpkt(5'h0B, 28'h0B0B0B0, 32'hB00BB00B, 4'h6));
    chk("t6_ptr_ok", 128'(data_o), 128'(32'hB00BB00B));
    drain(4);

    idle(2);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire

// File: doc/bsg_cache_pkt_in_buffer.md
Name: bsg_cache_pkt_in_buffer

Overview:
- Two-entry input staging buffer on the cache packet path, directly upstream of bsg_cache_pkt_decode.
- Accepts packed cache packets from the client with a valid/ready handshake.
- Registers the packets and presents the oldest one, whole and as unpacked fields, to the decode/tag-lookup stage with a valid/yumi handshake.
- Isolates client timing from the cache pipeline: no combinational path from input to output or from yumi_i to ready_o.

Parameters:
- addr_width_p, 28, byte address width of a packet.
- data_width_p, 32, data word width; must be a multiple of 8.
- mask_width_lp, data_width_p/8, byte-mask width (derived, not overridable).
- pkt_width_lp, 5+addr_width_p+data_width_p+mask_width_lp, packed packet width (69 at defaults; derived).

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- reset_n_i  in  1  asynchronous, active-low reset.
- v_i  in  1  client packet valid.
- cache_pkt_i  in  pkt_width_lp  packed packet {opcode[4:0], addr, data, mask}; opcode in the top 5 bits, mask in the LSBs.
- ready_o  out  1  buffer can accept a packet this cycle.
- v_o  out  1  head packet valid.
- cache_pkt_o  out  pkt_width_lp  head packet, packed.
- opcode_o  out  5  head opcode, i.e. cache_pkt_o[pkt_width_lp-1 -: 5].
- addr_o  out  addr_width_p  head address.
- data_o  out  data_width_p  head data.
- mask_o  out  mask_width_lp  head byte mask.
- yumi_i  in  1  consumer takes the head this cycle; legal only when v_o=1.
- count_o  out  2  occupancy, 0..2.

Behaviour:
Reset (async assert, sync-safe deassert):
- count_o=0, v_o=0, ready_o=1.
- Both storage entries and all data outputs = 0.
- Read/write pointers = 0.
- Reset asserted mid-transfer discards all contents immediately; no partial packet survives.

Storage:
- Two entries, circular, 1-bit write pointer and 1-bit read pointer, plus a 2-bit count.
- Strict FIFO order.

Enqueue:
- Occurs when v_i & ready_o at the clock edge: write cache_pkt_i to entry[wptr] and toggle wptr.
- v_i with ready_o=0 is ignored; the client must hold the packet.

Dequeue:
- Occurs when yumi_i & v_o: toggle rptr.
- yumi_i with v_o=0 is ignored and has no state effect; the bench flags it as a protocol error.

Outputs:
- ready_o = (count != 2), from registered state only.
- v_o = (count != 0).
- Data outputs = entry[rptr]; unpacked fields are pure slices of cache_pkt_o.

Latency and stability:
- A packet accepted at edge N appears on v_o/cache_pkt_o in the cycle after edge N. Minimum latency is 1 cycle; there is no bypass when empty.
- Head outputs stay stable while v_o=1 and yumi_i=0.

Count update:
- Enqueue only: +1.
- Dequeue only: -1.
- Both: unchanged, with both pointers advancing.
- Neither: unchanged.

Boundaries:
- Full (count=2): ready_o=0, so enqueue is impossible. A dequeue in that cycle gives count=1, and ready_o=1 the next cycle (one-cycle bubble to the client, accepted by design).
- Empty (count=0): v_o=0. An enqueue gives count=1 and v_o=1 the next cycle.
- count=1 with simultaneous enqueue and dequeue: the head advances to the new packet and count stays 1.
- Pointer wrap 1→0 is natural 1-bit overflow.

Opcode:
- No opcode interpretation is done here; all 32 opcode values pass through untouched to the decoder.

Throughput: sustains one packet per cycle when the consumer yumis every cycle.

Test Plan:
1. Reset: hold reset_n_i=0 with v_i=1 and random cache_pkt_i → ready_o=1, v_o=0, count_o=0, cache_pkt_o=0. Release reset → still empty.
2. Single packet: opcode=5'h10, addr=28'h0ABCDE0, data=32'hDEADBEEF, mask=4'hF, v_i for one cycle → next cycle v_o=1, opcode_o=5'h10, addr_o=28'h0ABCDE0, data_o=32'hDEADBEEF, mask_o=4'hF, count_o=1. Yumi → v_o=0 the next cycle.
3. Fill and back-pressure: enqueue packets A (data 1) and B (data 2) with yumi_i=0 → count_o=2, ready_o=0. Present C with v_i held 3 cycles → C not accepted and head stays A. Yumi once → ready_o=1 next cycle, then C accepted. Drain order observed: A, B, C.
4. Streaming: v_i=1 and yumi_i=v_o every cycle for 100 packets with data = index → 100 packets out in order with no drops or duplicates. count_o never exceeds 1 after the first cycle and pointer wrap is exercised.
5. Async reset mid-stream: assert reset_n_i between clock edges while count_o=2 → v_o, count_o and data outputs go to 0 immediately. After release, a new packet with data 32'h12345678 comes out first.
6. Stray yumi: yumi_i=1 while empty for 5 cycles, then enqueue packet D → D is held; count_o=1 and no pointer corruption.
